decode_extend: RTL and testbench

- JPEG decoder-side byte de-stuffer: the inverse of the encoder's 0xFF→0xFF00 extension.
- Accepts 32-bit words of entropy-coded stream, removes the stuffed 0x00 after each 0xFF, drops 0xFF fill bytes, and reports markers (0xFF followed by a non-zero, non-FF byte).
- Repacks the surviving bytes into 32-bit words for the Huffman decoder. Sits between the bitstream input buffer and the entropy decoder.

---
 rtl/decode_extend.sv | 172 +++++++++++++++++
 tb/tb_decode_extend.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_extend.sv
// JPEG byte de-stuffer: drops stuffed 0x00 and 0xFF fill, reports markers (DECODE_EXTEND_MARKER_EN), repacks bytes into 32-bit words.
// Bytes of a word accepted at cycle N appear at N+1; input stalls while more than 4 bytes are buffered or a flush is in progress.
module decode_extend #(
    parameter int PIC_PIX_IN_WIDTH = 32
) (
    input  logic                        clk_x8_i,
    input  logic                        rst_i,
    input  logic [PIC_PIX_IN_WIDTH-1:0] pic_data_in_i,
    input  logic                        pic_data_in_valid_i,
    output logic                        pic_data_in_ready_o,
    input  logic                        flush_i,
    output logic [PIC_PIX_IN_WIDTH-1:0] pic_data_out_o,
    output logic [2:0]                  pic_data_out_len_o,
    output logic                        pic_data_out_valid_o,
    input  logic                        pic_data_out_ready_i,
    output logic [7:0]                  marker_o,
    output logic                        marker_valid_o,
    output logic                        err_o
);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        FLUSH_DRAIN = 2'd1,
        FLUSH_PAD   = 2'd2
    } state_t;

    state_t      state;
    // Nine byte slots: without marker detection a carried 0xFF plus four bytes can yield five bytes.
    logic [71:0] buf_q;
    logic [3:0]  count;
    logic        pending_ff;

    logic        accept;
    logic        fire;

    logic [39:0] scan_dat;
    logic [2:0]  scan_cnt;
    logic        scan_pend;
    logic        scan_err;
    logic [7:0]  cur;
`ifdef DECODE_EXTEND_MARKER_EN
    logic [7:0]  scan_mk;
    logic        scan_mk_vld;
`endif

    always_comb begin
        scan_dat  = '0;
        scan_cnt  = '0;
        scan_pend = pending_ff;
        scan_err  = 1'b0;
        cur       = '0;
`ifdef DECODE_EXTEND_MARKER_EN
        scan_mk     = '0;
        scan_mk_vld = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            cur = pic_data_in_i[31-8*i -: 8];
            if (scan_pend) begin
                if (cur == 8'h00) begin
                    scan_dat  = scan_dat | ({8'hFF, 32'h0} >> {scan_cnt, 3'b000});
                    scan_cnt  = scan_cnt + 3'd1;
                    scan_pend = 1'b0;
                end else if (cur != 8'hFF) begin
                    scan_pend = 1'b0;
`ifdef DECODE_EXTEND_MARKER_EN
                    if (scan_mk_vld) scan_err = 1'b1;
                    scan_mk_vld = 1'b1;
                    scan_mk     = cur;
`else
                    scan_dat = scan_dat | ({8'hFF, 32'h0} >> {scan_cnt, 3'b000});
                    scan_cnt = scan_cnt + 3'd1;
                    scan_dat = scan_dat | ({cur, 32'h0} >> {scan_cnt, 3'b000});
                    scan_cnt = scan_cnt + 3'd1;
                    scan_err = 1'b1;
`endif
                end
            end else if (cur == 8'hFF) begin
                scan_pend = 1'b1;
            end else begin
                scan_dat = scan_dat | ({cur, 32'h0} >> {scan_cnt, 3'b000});
                scan_cnt = scan_cnt + 3'd1;
            end
        end
    end

    logic [31:0] pad_mask;

    always_comb begin
        pic_data_in_ready_o = (state == RUN) && (count <= 4'd4);
        case (count)
            4'd1:    pad_mask = 32'hFF00_0000;
            4'd2:    pad_mask = 32'hFFFF_0000;
            4'd3:    pad_mask = 32'hFFFF_FF00;
            default: pad_mask = 32'h0000_0000;
        endcase
        if (state == FLUSH_PAD) begin
            pic_data_out_valid_o = 1'b1;
            pic_data_out_o       = buf_q[71:40] & pad_mask;
            pic_data_out_len_o   = count[2:0];
        end else begin
            pic_data_out_valid_o = (count >= 4'd4);
            pic_data_out_o       = buf_q[71:40];
            pic_data_out_len_o   = pic_data_out_valid_o ? 3'd4 : 3'd0;
        end
    end

    assign accept = pic_data_in_valid_i && pic_data_in_ready_o;
    assign fire   = pic_data_out_valid_o && pic_data_out_ready_i;

    logic [3:0]  base;
    logic [71:0] next_buf;
    logic [3:0]  next_count;

    // New bytes land directly behind whatever survives this cycle's output shift.
    always_comb begin
        base       = fire ? (count - 4'd4) : count;
        next_buf   = fire ? {buf_q[39:0], 32'h0} : buf_q;
        next_count = base;
        if (accept) begin
            next_buf   = next_buf | ({scan_dat, 32'h0} >> {base, 3'b000});
            next_count = base + {1'b0, scan_cnt};
        end
    end

    always_ff @(posedge clk_x8_i) begin
        if (rst_i) begin
            state          <= RUN;
            buf_q          <= '0;
            count          <= '0;
            pending_ff     <= 1'b0;
            marker_o       <= '0;
            marker_valid_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            marker_valid_o <= 1'b0;
            if (accept) begin
                pending_ff <= scan_pend;
                if (scan_err) err_o <= 1'b1;
`ifdef DECODE_EXTEND_MARKER_EN
                if (scan_mk_vld) begin
                    marker_o       <= scan_mk;
                    marker_valid_o <= 1'b1;
                end
`endif
            end
            case (state)
                RUN, FLUSH_DRAIN: begin
                    buf_q <= next_buf;
                    count <= next_count;
                    if (state == RUN) begin
                        if (flush_i) state <= FLUSH_DRAIN;
                    end else if (count < 4'd4) begin
                        // A dangling 0xFF at end of scan cannot be resolved.
                        if (pending_ff) err_o <= 1'b1;
                        pending_ff <= 1'b0;
                        state      <= (count != 4'd0) ? FLUSH_PAD : RUN;
                    end
                end
                FLUSH_PAD: begin
                    if (fire) begin
                        buf_q      <= '0;
                        count      <= '0;
                        pending_ff <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_extend.sv
`timescale 1ns/1ps
module tb_decode_extend;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_len;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  marker;
    logic        marker_valid;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_extend #(.PIC_PIX_IN_WIDTH(32)) dut (
        .clk_x8_i            (clk),
        .rst_i               (rst),
        .pic_data_in_i       (in_data),
        .pic_data_in_valid_i (in_valid),
        .pic_data_in_ready_o (in_ready),
        .flush_i             (flush),
        .pic_data_out_o      (out_data),
        .pic_data_out_len_o  (out_len),
        .pic_data_out_valid_o(out_valid),
        .pic_data_out_ready_i(out_ready),
        .marker_o            (marker),
        .marker_valid_o      (marker_valid),
        .err_o               (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: a byte queue of de-stuffed stream bytes plus the scan rules.
    logic [7:0] mq[$];
    bit         m_pend;
    bit         m_err;
    bit         m_flushing;
    bit         exp_mv;
    logic [7:0] exp_mk;

    task automatic model_word(input logic [31:0] w);
        logic [7:0] b;
        int         nmk;
        nmk = 0;
        for (int i = 0; i < 4; i++) begin
            b = w[31-8*i -: 8];
            if (m_pend) begin
                m_pend = 0;
                if (b == 8'h00) mq.push_back(8'hFF);
                else if (b == 8'hFF) m_pend = 1;
                else begin
`ifdef DECODE_EXTEND_MARKER_EN
                    nmk++;
                    exp_mk = b;
`else
                    mq.push_back(8'hFF);
                    mq.push_back(b);
                    m_err = 1;
`endif
                end
            end else if (b == 8'hFF) begin
                m_pend = 1;
            end else begin
                mq.push_back(b);
            end
        end
        if (nmk > 0) exp_mv = 1;
        if (nmk > 1) m_err = 1;
    endtask

    int          qs;
    int          elen;
    bit          fl0;
    logic [31:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_pend     = 0;
            m_err      = 0;
            m_flushing = 0;
            exp_mv     = 0;
        end else begin
            qs  = mq.size();
            fl0 = m_flushing;
            check("mon_in_ready", 32'(in_ready), 32'(!m_flushing && qs <= 4));
            if (!(m_flushing && qs > 0 && qs < 4))
                check("mon_out_valid", 32'(out_valid), 32'(qs >= 4));
            if (out_valid) begin
                elen  = (qs < 4) ? qs : 4;
                exp_w = '0;
                for (int k = 0; k < elen; k++) exp_w[31-8*k -: 8] = mq[k];
                check("mon_out_len", 32'(out_len), elen);
                check("mon_out_data", out_data, exp_w);
                if (out_ready) begin
                    for (int k = 0; k < elen; k++) void'(mq.pop_front());
                    if (elen < 4) m_flushing = 0;
                end
            end
            check("mon_marker_valid", 32'(marker_valid), 32'(exp_mv));
            if (exp_mv) check("mon_marker", 32'(marker), 32'(exp_mk));
            exp_mv = 0;
            if (in_valid && in_ready) model_word(in_data);
            if (fl0 && qs == 0) m_flushing = 0;
            if (flush && !fl0) begin
                m_flushing = 1;
                if (m_pend) begin
                    m_err  = 1;
                    m_pend = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1;
        in_valid = 0;
        flush    = 0;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic send(input logic [31:0] w);
        int g;
        g        = 0;
        in_data  = w;
        in_valid = 1;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        check("send_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic wait_valid(input string tag);
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
            tick();
            g++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    logic [7:0]  rb;
    logic [31:0] rw;
    int          g2;

    initial begin
        rst       = 1;
        in_data   = '0;
        in_valid  = 0;
        flush     = 0;
        out_ready = 1;

        // Reset state
        do_reset();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_len", 32'(out_len), 0);
        check("rst_marker", 32'(marker), 0);
        check("rst_marker_valid", 32'(marker_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Stuff removal
        send(32'h12FF_0034);
        send(32'h5678_9ABC);
        check("stuff_valid", 32'(out_valid), 1);
        check("stuff_data", out_data, 32'h12FF_3456);
        check("stuff_len", 32'(out_len), 4);
        tick();
        check("stuff_rest_valid", 32'(out_valid), 0);
        check("stuff_rest_data", out_data, 32'h789A_BC00);
        do_flush();
        wait_valid("stuff_pad_wait");
        check("stuff_pad_len", 32'(out_len), 3);
        check("stuff_pad_data", out_data, 32'h789A_BC00);
        tick();
        check("stuff_pad_done_ready", 32'(in_ready), 1);

        // Cross-word 0xFF
        do_reset();
        send(32'h1122_33FF);
        send(32'h0044_5566);
        check("xword_data", out_data, 32'h1122_33FF);
        check("xword_valid", 32'(out_valid), 1);
        tick();
        check("xword_rest", out_data, 32'h4455_6600);
        do_flush();
        wait_valid("xword_pad_wait");
        check("xword_pad_len", 32'(out_len), 3);
        tick();
        check("xword_err", 32'(err), 0);

        // Marker in mid-word
        do_reset();
        send(32'hAAFF_D0BB);
`ifdef DECODE_EXTEND_MARKER_EN
        check("mk_valid", 32'(marker_valid), 1);
        check("mk_code", 32'(marker), 32'hD0);
        check("mk_out_valid", 32'(out_valid), 0);
        check("mk_buffered", out_data, 32'hAABB_0000);
        check("mk_err", 32'(err), 0);
        tick();
        check("mk_pulse_end", 32'(marker_valid), 0);
        check("mk_code_held", 32'(marker), 32'hD0);
`else
        check("mk_off_valid", 32'(marker_valid), 0);
        check("mk_off_code", 32'(marker), 0);
        check("mk_off_data", out_data, 32'hAAFF_D0BB);
        check("mk_off_err", 32'(err), 1);
        tick();
`endif

        // Two markers in one word
        do_reset();
        send(32'hFFD0_FFD1);
`ifdef DECODE_EXTEND_MARKER_EN
        check("mk2_code", 32'(marker), 32'hD1);
        check("mk2_valid", 32'(marker_valid), 1);
`else
        check("mk2_off_data", out_data, 32'hFFD0_FFD1);
`endif
        check("mk2_err", 32'(err), 1);
        tick();

        // Fill bytes and EOI, then flush partial word
        do_reset();
        send(32'hCAFE_FFFF);
        send(32'hFFFF_FFD9);
`ifdef DECODE_EXTEND_MARKER_EN
        check("eoi_code", 32'(marker), 32'hD9);
        check("eoi_out_valid", 32'(out_valid), 0);
        tick();
        do_flush();
        wait_valid("eoi_pad_wait");
        check("eoi_pad_data", out_data, 32'hCAFE_0000);
        check("eoi_pad_len", 32'(out_len), 2);
        tick();
        check("eoi_err", 32'(err), 0);
`else
        check("eoi_off_data", out_data, 32'hCAFE_FFD9);
        check("eoi_off_err", 32'(err), 1);
        tick();
`endif

        // Dangling 0xFF at flush
        do_reset();
        send(32'h1122_33FF);
        do_flush();
        wait_valid("dangle_wait");
        check("dangle_data", out_data, 32'h1122_3300);
        check("dangle_len", 32'(out_len), 3);
        tick();
        check("dangle_err", 32'(err), 1);

        // Backpressure
        do_reset();
        out_ready = 0;
        send(32'h0102_0304);
        send(32'h0506_0708);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_data", out_data, 32'h0102_0304);
        tick();
        tick();
        check("bp_held", out_data, 32'h0102_0304);
        out_ready = 1;
        tick();
        check("bp_second", out_data, 32'h0506_0708);
        check("bp_second_valid", 32'(out_valid), 1);
        check("bp_in_ready_back", 32'(in_ready), 1);
        tick();
        check("bp_drained", 32'(out_valid), 0);

        // Reset during FLUSH_PAD
        do_reset();
        out_ready = 0;
        send(32'hCAFE_FFFF);
        do_flush();
        wait_valid("rstpad_wait");
        check("rstpad_len", 32'(out_len), 2);
        rst = 1;
        tick();
        rst = 0;
        check("rstpad_valid", 32'(out_valid), 0);
        check("rstpad_data", out_data, 0);
        check("rstpad_len0", 32'(out_len), 0);
        check("rstpad_err", 32'(err), 0);
        check("rstpad_in_ready", 32'(in_ready), 1);
        out_ready = 1;

        // Randomized traffic against the byte-queue model
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int j = 0; j < 4; j++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: rb = 8'hFF;
                    3, 4:    rb = 8'h00;
                    5:       rb = 8'hD0 + 8'($urandom_range(0, 7));
                    default: rb = 8'($urandom_range(0, 255));
                endcase
                rw[31-8*j -: 8] = rb;
            end
            in_data   = rw;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = !m_flushing && ($urandom_range(0, 79) == 0);
            tick();
        end
        in_valid  = 0;
        flush     = 0;
        out_ready = 1;
        g2 = 0;
        while (m_flushing && g2 < 200) begin
            tick();
            g2++;
        end
        do_flush();
        g2 = 0;
        while ((m_flushing || mq.size() != 0) && g2 < 200) begin
            tick();
            g2++;
        end
        check("rand_drain_valid", 32'(out_valid), 0);
        check("rand_drain_ready", 32'(in_ready), 1);
        check("rand_err", 32'(err), 32'(m_err));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
